rng_fill_ctrl: RTL and testbench

RNG_FILL_CTRL -- requirements
Module: rng_fill_ctrl

---
 rtl/rng_fill_if.sv | 27 ++
 rtl/rng_fill_ctrl.sv | 113 +++++++++++
 tb/tb_rng_fill_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rng_fill_if.sv
// rng_fill_if: control, request and status bundle between a fill requester,
//   the RNG RAM write port and rng_fill_ctrl.
// Latency: none (wires only). Backpressure: request side is one-outstanding, ack-paced.
// Ports: master = the fill controller, slave = the environment (requester + RAM).
interface rng_fill_if;
  logic       start_i;    // fill request
  logic       abort_i;    // cancel fill in progress
  logic [8:0] base_i;     // first RAM word address
  logic [9:0] len_i;      // words to fill (clamped to 512)
  logic       we_rng_o;   // one-cycle write request
  logic [8:0] addr_rng_o; // address of the current request
  logic       ack_rng_i;  // one-cycle completion pulse from the RAM
  logic       busy_o;     // fill in progress
  logic       done_o;     // one-cycle normal-completion pulse
  logic       err_o;      // sticky timeout flag
  logic [9:0] count_o;    // words acknowledged since last accepted start

  modport master (
    input  start_i, abort_i, base_i, len_i, ack_rng_i,
    output we_rng_o, addr_rng_o, busy_o, done_o, err_o, count_o
  );

  modport slave (
    output start_i, abort_i, base_i, len_i, ack_rng_i,
    input  we_rng_o, addr_rng_o, busy_o, done_o, err_o, count_o
  );
endinterface

// File: rtl/rng_fill_ctrl.sv
// rng_fill_ctrl: fills a run of RNG RAM words, one write request at a time, with per-word ack timeout.
// Latency: first request one cycle after an accepted start; one word per 2 cycles at best.
// Backpressure: a single outstanding request; the next is issued only after the RAM acks.
// Ports: clk_i, rst_ni (async active-low); bus (rng_fill_if.master) carries start/abort/base/len
//   in, we/addr requests out, ack in, and busy/done/err/count status out.
module rng_fill_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  rng_fill_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  // Timer value seen during the last permitted WAIT cycle: TIMEOUT_CYC WAIT
  // cycles elapse without an ack before the move to ERR.
  localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT_CYC - 1);
  localparam logic [9:0] LEN_MAX    = 10'd512;

  state_t     state_q, state_d;
  logic [8:0] addr_q,  addr_d;
  logic [9:0] len_q,   len_d;
  logic [9:0] count_q, count_d;
  logic [9:0] timer_q, timer_d;

  logic [9:0] len_clamped;
  logic [9:0] count_inc;

  assign len_clamped = (bus.len_i > LEN_MAX) ? LEN_MAX : bus.len_i;
  assign count_inc   = count_q + 10'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      count_q <= count_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    count_d = count_q;
    timer_d = timer_q;

    case (state_q)
      // ERR is IDLE with err_o raised; a new start clears it by leaving ERR.
      S_IDLE, S_ERR: begin
        if (bus.start_i) begin
          addr_d  = bus.base_i;
          len_d   = len_clamped;
          count_d = '0;
          timer_d = '0;
          state_d = (len_clamped != 10'd0) ? S_ISSUE : S_DONE;
        end
      end

      S_ISSUE: begin
        timer_d = '0;
        state_d = bus.abort_i ? S_IDLE : S_WAIT;
      end

      S_WAIT: begin
        // Abort beats ack (the ack is dropped); ack beats timeout.
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else if (bus.ack_rng_i) begin
          count_d = count_inc;
          addr_d  = addr_q + 9'd1;  // wraps 0x1FF -> 0x000
          timer_d = '0;
          state_d = (count_inc == len_q) ? S_DONE : S_ISSUE;
        end else if (timer_q == TIMER_LAST) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 10'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode straight from registered state so an async reset drops them at once.
  assign bus.we_rng_o   = (state_q == S_ISSUE);
  assign bus.addr_rng_o = addr_q;
  assign bus.busy_o     = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.done_o     = (state_q == S_DONE);
  assign bus.err_o      = (state_q == S_ERR);
  assign bus.count_o    = count_q;

endmodule

// File: tb/tb_rng_fill_ctrl.sv
// tb_rng_fill_ctrl: directed bench for rng_fill_ctrl with TIMEOUT_CYC=8.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: the RAM side is modelled by a per-request ack delay.
module tb_rng_fill_ctrl;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;

  rng_fill_if bus ();

  rng_fill_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] seen_addr[$];
  int n_done;
  int done_cyc;
  int err_cyc;
  int last_we_cyc;
  bit hit_limit;

  // Starts a fill and plays the RAM: each request is acked ack_dly cycles later,
  // except word stall_word (never acked). Abort is raised together with the ack
  // of word abort_word. Returns when done/err is seen, one cycle after an abort,
  // or after max_cyc cycles.
  task automatic run_fill(input logic [8:0] base, input logic [9:0] len, input int ack_dly,
                          input int stall_word, input int abort_word, input int max_cyc);
    int cd;
    int idx;
    int cyc;
    bit aborted;
    seen_addr.delete();
    n_done = 0; done_cyc = -1; err_cyc = -1; last_we_cyc = -1; hit_limit = 1'b0;
    cd = 0; idx = 0; aborted = 1'b0;
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.base_i = base; bus.len_i = len;
    for (cyc = 0; cyc < max_cyc; cyc++) begin
      @(negedge clk_i);
      bus.start_i = 1'b0; bus.ack_rng_i = 1'b0; bus.abort_i = 1'b0;
      if (aborted) break;
      if (bus.done_o) begin n_done++; done_cyc = cyc; break; end
      if (bus.err_o) begin err_cyc = cyc; break; end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.ack_rng_i = 1'b1;
          if (idx - 1 == abort_word) begin bus.abort_i = 1'b1; aborted = 1'b1; end
        end
      end
      if (bus.we_rng_o) begin
        seen_addr.push_back(bus.addr_rng_o);
        last_we_cyc = cyc;
        if (idx != stall_word) cd = ack_dly;
        idx++;
      end
    end
    if (cyc >= max_cyc) hit_limit = 1'b1;
    bus.ack_rng_i = 1'b0; bus.abort_i = 1'b0; bus.start_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.ack_rng_i = 1'b0;
    bus.base_i = '0; bus.len_i = '0;
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if ({bus.we_rng_o, bus.busy_o, bus.done_o, bus.err_o} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {bus.we_rng_o, bus.busy_o, bus.done_o, bus.err_o});
    end
    n_cmp++;
    if (bus.addr_rng_o !== 9'h000 || bus.count_o !== 10'd0) begin
      n_bad++; $display("FAIL reset_addr_count: got addr %h count %0d want 0/0", bus.addr_rng_o, bus.count_o);
    end
    rst_ni = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    logic [8:0] exp_a[4];
    exp_a = '{9'h010, 9'h011, 9'h012, 9'h013};
    run_fill(9'h010, 10'd4, 3, -1, -1, 200);
    n_cmp++;
    if (hit_limit !== 1'b0 || seen_addr.size() != 4) begin
      n_bad++; $display("FAIL basic_nreq: got %0d reqs (limit %0b) want 4", seen_addr.size(), hit_limit);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (seen_addr[i] !== exp_a[i]) begin
          n_bad++; $display("FAIL basic_addr%0d: got %h want %h", i, seen_addr[i], exp_a[i]);
        end
      end
    end
    n_cmp++;
    if (n_done != 1 || bus.count_o !== 10'd4 || bus.err_o !== 1'b0) begin
      n_bad++; $display("FAIL basic_end: got done %0d count %0d err %b want 1/4/0", n_done, bus.count_o, bus.err_o);
    end
    @(negedge clk_i);
    n_cmp++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_bad++; $display("FAIL basic_done_once: got done %b busy %b want 0/0", bus.done_o, bus.busy_o);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] exp_a[4];
    exp_a = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
    run_fill(9'h1FE, 10'd4, 1, -1, -1, 200);
    n_cmp++;
    if (hit_limit !== 1'b0 || seen_addr.size() != 4 || n_done != 1) begin
      n_bad++; $display("FAIL wrap_nreq: got %0d reqs done %0d want 4/1", seen_addr.size(), n_done);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (seen_addr[i] !== exp_a[i]) begin
          n_bad++; $display("FAIL wrap_addr%0d: got %h want %h", i, seen_addr[i], exp_a[i]);
        end
      end
    end
  endtask

  task automatic test_len_bounds();
    run_fill(9'h033, 10'd0, 1, -1, -1, 20);
    n_cmp++;
    if (seen_addr.size() != 0 || n_done != 1 || done_cyc != 0) begin
      n_bad++; $display("FAIL len0: got %0d reqs done %0d at cyc %0d want 0/1/0", seen_addr.size(), n_done, done_cyc);
    end
    @(negedge clk_i);
    run_fill(9'h005, 10'd600, 1, -1, -1, 2000);
    n_cmp++;
    if (hit_limit !== 1'b0 || seen_addr.size() != 512 || bus.count_o !== 10'd512) begin
      n_bad++; $display("FAIL len_clamp: got %0d reqs count %0d want 512/512", seen_addr.size(), bus.count_o);
    end
    n_cmp++;
    if (seen_addr.size() == 0 || seen_addr[seen_addr.size()-1] !== 9'h004) begin
      n_bad++; $display("FAIL len_clamp_last: got %0d reqs, last addr wrong, want last 004", seen_addr.size());
    end
    @(negedge clk_i);
  endtask

  task automatic test_ack_at_timeout();
    // Ack lands on the 8th WAIT cycle, same cycle as the timeout: ack must win.
    run_fill(9'h080, 10'd2, 8, -1, -1, 100);
    n_cmp++;
    if (n_done != 1 || bus.count_o !== 10'd2 || bus.err_o !== 1'b0) begin
      n_bad++; $display("FAIL ack_wins: got done %0d count %0d err %b want 1/2/0", n_done, bus.count_o, bus.err_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_timeout();
    run_fill(9'h100, 10'd3, 3, 1, -1, 100);
    n_cmp++;
    if (err_cyc < 0 || err_cyc - last_we_cyc != 9) begin
      n_bad++; $display("FAIL timeout_cycles: got err at %0d, last req at %0d, want gap 9", err_cyc, last_we_cyc);
    end
    n_cmp++;
    if (bus.err_o !== 1'b1 || bus.count_o !== 10'd1 || bus.busy_o !== 1'b0) begin
      n_bad++; $display("FAIL timeout_state: got err %b count %0d busy %b want 1/1/0", bus.err_o, bus.count_o, bus.busy_o);
    end
    // In ERR, abort and a stray ack do nothing; err stays sticky.
    bus.abort_i = 1'b1; bus.ack_rng_i = 1'b1;
    @(negedge clk_i);
    bus.abort_i = 1'b0; bus.ack_rng_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (bus.err_o !== 1'b1 || bus.count_o !== 10'd1) begin
      n_bad++; $display("FAIL err_sticky: got err %b count %0d want 1/1", bus.err_o, bus.count_o);
    end
    bus.start_i = 1'b1; bus.base_i = 9'h0AA; bus.len_i = 10'd1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    n_cmp++;
    if (bus.err_o !== 1'b0 || bus.count_o !== 10'd0 || bus.we_rng_o !== 1'b1 || bus.addr_rng_o !== 9'h0AA) begin
      n_bad++; $display("FAIL err_clear: got err %b count %0d we %b addr %h want 0/0/1/0aa",
                        bus.err_o, bus.count_o, bus.we_rng_o, bus.addr_rng_o);
    end
    @(negedge clk_i);
    bus.ack_rng_i = 1'b1;
    @(negedge clk_i);
    bus.ack_rng_i = 1'b0;
    n_cmp++;
    if (bus.done_o !== 1'b1 || bus.count_o !== 10'd1) begin
      n_bad++; $display("FAIL err_restart_done: got done %b count %0d want 1/1", bus.done_o, bus.count_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_abort();
    run_fill(9'h020, 10'd5, 2, -1, 2, 100);
    n_cmp++;
    if (bus.busy_o !== 1'b0 || bus.we_rng_o !== 1'b0 || bus.done_o !== 1'b0 || n_done != 0) begin
      n_bad++; $display("FAIL abort_idle: got busy %b we %b done %b want 0/0/0", bus.busy_o, bus.we_rng_o, bus.done_o);
    end
    n_cmp++;
    if (bus.count_o !== 10'd2 || seen_addr.size() != 3) begin
      n_bad++; $display("FAIL abort_count: got count %0d reqs %0d want 2/3", bus.count_o, seen_addr.size());
    end
    bus.ack_rng_i = 1'b1;
    @(negedge clk_i);
    bus.ack_rng_i = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (bus.count_o !== 10'd2 || bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_bad++; $display("FAIL abort_stray_ack: got count %0d done %b busy %b want 2/0/0", bus.count_o, bus.done_o, bus.busy_o);
    end
  endtask

  task automatic test_busy_start_and_reset();
    @(negedge clk_i);
    bus.start_i = 1'b1; bus.base_i = 9'h040; bus.len_i = 10'd3;
    @(negedge clk_i);
    bus.start_i = 1'b0;                              // ISSUE, addr 0x040
    @(negedge clk_i);                                // WAIT
    bus.start_i = 1'b1; bus.base_i = 9'h150; bus.len_i = 10'd7;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    n_cmp++;
    if (bus.busy_o !== 1'b1 || bus.addr_rng_o !== 9'h040 || bus.we_rng_o !== 1'b0) begin
      n_bad++; $display("FAIL busy_start_ignored: got busy %b addr %h we %b want 1/040/0", bus.busy_o, bus.addr_rng_o, bus.we_rng_o);
    end
    bus.ack_rng_i = 1'b1;
    @(negedge clk_i);
    bus.ack_rng_i = 1'b0;
    n_cmp++;
    if (bus.we_rng_o !== 1'b1 || bus.addr_rng_o !== 9'h041 || bus.count_o !== 10'd1) begin
      n_bad++; $display("FAIL busy_next_req: got we %b addr %h count %0d want 1/041/1", bus.we_rng_o, bus.addr_rng_o, bus.count_o);
    end
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({bus.we_rng_o, bus.busy_o, bus.done_o, bus.err_o} !== 4'b0000 ||
        bus.addr_rng_o !== 9'h000 || bus.count_o !== 10'd0) begin
      n_bad++; $display("FAIL async_reset: got we %b busy %b done %b err %b addr %h count %0d want all 0",
                        bus.we_rng_o, bus.busy_o, bus.done_o, bus.err_o, bus.addr_rng_o, bus.count_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);
    n_cmp++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.we_rng_o !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle: got done %b busy %b we %b want 0/0/0", bus.done_o, bus.busy_o, bus.we_rng_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_len_bounds();
    test_ack_at_timeout();
    test_timeout();
    test_abort();
    test_busy_start_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
